// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between a fetch requester and a load/store requester.
// An ID FIFO tracks granted transactions so the in-order responses reach the requester that owns them.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIORITY   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    spurious_rvalid_o
);

    localparam int   PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int   CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic ID_INSTR  = 1'b0;
    localparam logic ID_DATA   = 1'b1;
    localparam logic PRIO_DATA = (DATA_PRIORITY != 0);

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t                 state_reg;
    logic                   locked_sel_reg;
    logic                   last_grant_reg;
    logic [PTR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;
    logic [MAX_OUTSTANDING-1:0] id_vec;

    logic full, empty, active, sel_data, grant, push, pop, head_id;

    assign full  = (count_reg == CNT_WIDTH'(MAX_OUTSTANDING));
    assign empty = (count_reg == '0);

    // Selection: LOCKED holds the latched requester; ARB arbitrates only while the FIFO has room.
    always_comb begin
        active   = 1'b0;
        sel_data = 1'b0;
        if (state_reg == LOCKED) begin
            active   = 1'b1;
            sel_data = locked_sel_reg;
        end else if (!full && (instr_req_i || data_req_i)) begin
            active   = 1'b1;
            sel_data = data_req_i &&
                       (!instr_req_i || PRIO_DATA || (last_grant_reg == ID_INSTR));
        end
    end

    assign mem_req_o   = active;
    assign mem_addr_o  = !active ? '0 : (sel_data ? data_addr_i : instr_addr_i);
    assign mem_we_o    = active && sel_data && data_we_i;
    assign mem_be_o    = !active ? '0 : (sel_data ? data_be_i : '1);
    assign mem_wdata_o = (active && sel_data) ? data_wdata_i : '0;

    assign grant       = active && mem_gnt_i;
    assign push        = grant;
    assign instr_gnt_o = grant && !sel_data;
    assign data_gnt_o  = grant && sel_data;

    assign head_id           = id_vec[rd_ptr_reg];
    assign pop               = mem_rvalid_i && !empty;
    assign instr_rvalid_o    = pop && (head_id == ID_INSTR);
    assign data_rvalid_o     = pop && (head_id == ID_DATA);
    assign spurious_rvalid_o = mem_rvalid_i && empty;
    assign rdata_o           = mem_rdata_i;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push)
            wr_ptr_next = (wr_ptr_reg == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id
            logic id_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    id_reg <= ID_INSTR;
                else if (push && (wr_ptr_reg == PTR_WIDTH'(gi)))
                    id_reg <= sel_data;
            end
            assign id_vec[gi] = id_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            locked_sel_reg <= ID_INSTR;
            last_grant_reg <= ID_DATA;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (grant)
                last_grant_reg <= sel_data;
            case (state_reg)
                ARB: begin
                    if (active && !mem_gnt_i) begin
                        state_reg      <= LOCKED;
                        locked_sel_reg <= sel_data;
                    end
                end
                LOCKED: begin
                    if (mem_gnt_i)
                        state_reg <= ARB;
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    // A locked requester must keep its request up until it is granted.
    lock_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == LOCKED) |-> (locked_sel_reg ? data_req_i : instr_req_i));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grant/response events,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o, spurious_rvalid_o;
    logic [3:0]  mem_be_o;

    logic        p_instr_gnt, p_instr_rvalid, p_data_gnt, p_data_rvalid;
    logic [31:0] p_rdata, p_mem_addr, p_mem_wdata;
    logic        p_mem_req, p_mem_we, p_spurious;
    logic [3:0]  p_mem_be;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;
    ev_t exp_q[$];

    localparam int EV_GNT_I = 0, EV_GNT_D = 1, EV_RV_I = 2, EV_RV_D = 3, EV_SPUR = 4;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIORITY(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .spurious_rvalid_o(spurious_rvalid_o)
    );

    // Data-priority variant sharing the same stimulus; only checked for starvation.
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIORITY(1)) u_dut_prio (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(p_instr_gnt), .instr_rvalid_o(p_instr_rvalid),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(p_data_gnt), .data_rvalid_o(p_data_rvalid), .rdata_o(p_rdata),
        .mem_req_o(p_mem_req), .mem_addr_o(p_mem_addr), .mem_we_o(p_mem_we),
        .mem_be_o(p_mem_be), .mem_wdata_o(p_mem_wdata),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .spurious_rvalid_o(p_spurious)
    );

    task automatic expect_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int kind, input logic [31:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=0x%0h expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL event: got kind=%0d val=0x%0h expected kind=%0d val=0x%0h",
                         kind, val, e.kind, e.val);
            end else begin
                $display("t=%0t event kind=%0d val=0x%0h ok", $time, kind, val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (instr_gnt_o)       mon(EV_GNT_I, mem_addr_o);
        if (data_gnt_o)        mon(EV_GNT_D, mem_addr_o);
        if (instr_rvalid_o)    mon(EV_RV_I, rdata_o);
        if (data_rvalid_o)     mon(EV_RV_D, rdata_o);
        if (spurious_rvalid_o) mon(EV_SPUR, rdata_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic g, input logic rv, input logic [31:0] rd);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    task automatic idle_inputs();
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
        chk({tag, "_mem_be"}, 32'(mem_be_o), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_gnts"}, 32'({instr_gnt_o, data_gnt_o}), 32'h0);
        chk({tag, "_rvalids"}, 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        @(negedge clk);
        check_quiet("reset");
        tick();
        rst_n = 1'b1;

        // 1: fetch only, grant every cycle, response one cycle later
        drv(1, 32'h100, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h100);
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req_o), 32'h1);
        chk("t1_mem_we", 32'(mem_we_o), 32'h0);
        chk("t1_mem_be", 32'(mem_be_o), 32'hF);
        chk("t1_mem_wdata", mem_wdata_o, 32'h0);
        tick();
        drv(1, 32'h101, 0, 0, 1, 1, 32'hA0);
        expect_ev(EV_GNT_I, 32'h101); expect_ev(EV_RV_I, 32'hA0);
        tick();
        drv(1, 32'h102, 0, 0, 1, 1, 32'hA1);
        expect_ev(EV_GNT_I, 32'h102); expect_ev(EV_RV_I, 32'hA1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hA2);
        expect_ev(EV_RV_I, 32'hA2);
        tick();
        do_reset();

        // 2: both request every cycle; round-robin alternates, priority variant starves fetch
        data_be_i = 4'hF;
        drv(1, 32'h200, 1, 32'h300, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h200);
        @(negedge clk);
        chk("t2_prio_data_gnt", 32'(p_data_gnt), 32'h1);
        chk("t2_prio_instr_gnt", 32'(p_instr_gnt), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h200, 1, 32'h300, 1, 1, 32'hB0 + 32'(i));
            if (i % 2 == 0) begin
                expect_ev(EV_GNT_D, 32'h300); expect_ev(EV_RV_I, 32'hB0 + 32'(i));
            end else begin
                expect_ev(EV_GNT_I, 32'h200); expect_ev(EV_RV_D, 32'hB0 + 32'(i));
            end
            @(negedge clk);
            chk("t2_prio_data_gnt", 32'(p_data_gnt), 32'h1);
            chk("t2_prio_instr_gnt", 32'(p_instr_gnt), 32'h0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 1, 32'hB3);
        expect_ev(EV_RV_D, 32'hB3);
        tick();

        // 3: locked data write is not preempted by a later fetch request
        data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD;
        drv(0, 0, 1, 32'h40, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin instr_req_i = 1'b1; instr_addr_i = 32'h500; end
            if (i == 3) begin mem_gnt_i = 1'b1; expect_ev(EV_GNT_D, 32'h40); end
            @(negedge clk);
            chk("t3_mem_addr", mem_addr_o, 32'h40);
            chk("t3_mem_we", 32'(mem_we_o), 32'h1);
            chk("t3_mem_be", 32'(mem_be_o), 32'h3);
            chk("t3_mem_wdata", mem_wdata_o, 32'hDEAD);
            tick();
        end
        data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = 32'h0;
        drv(1, 32'h500, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h500);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hC0);
        expect_ev(EV_RV_D, 32'hC0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hC1);
        expect_ev(EV_RV_I, 32'hC1);
        tick();

        // 4: FIFO full blocks requests; a pop this cycle does not unblock until the next
        drv(1, 32'h600, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h600);
        tick();
        expect_ev(EV_GNT_I, 32'h600);
        tick();
        drv(1, 32'h600, 0, 0, 1, 1, 32'hD0);
        expect_ev(EV_RV_I, 32'hD0);
        @(negedge clk);
        chk("t4_full_mem_req", 32'(mem_req_o), 32'h0);
        tick();
        drv(1, 32'h600, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h600);
        @(negedge clk);
        chk("t4_resume_mem_req", 32'(mem_req_o), 32'h1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hD1);
        expect_ev(EV_RV_I, 32'hD1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hD2);
        expect_ev(EV_RV_I, 32'hD2);
        tick();

        // 5: interleaved owners, responses routed in grant order
        drv(1, 32'h700, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h700);
        tick();
        data_be_i = 4'hF;
        drv(0, 0, 1, 32'h800, 1, 1, 32'hE0);
        expect_ev(EV_GNT_D, 32'h800); expect_ev(EV_RV_I, 32'hE0);
        tick();
        data_be_i = 4'h0;
        drv(1, 32'h701, 0, 0, 1, 1, 32'hE1);
        expect_ev(EV_GNT_I, 32'h701); expect_ev(EV_RV_D, 32'hE1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hE2);
        expect_ev(EV_RV_I, 32'hE2);
        tick();

        // 6: spurious response, then reset with two outstanding clears the FIFO
        drv(0, 0, 0, 0, 0, 1, 32'hF0);
        expect_ev(EV_SPUR, 32'hF0);
        @(negedge clk);
        chk("t6_spur_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        tick();
        drv(1, 32'h900, 0, 0, 1, 0, 0);
        expect_ev(EV_GNT_I, 32'h900);
        tick();
        expect_ev(EV_GNT_I, 32'h900);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("t6_in_reset");
        tick();
        rst_n = 1'b1;
        drv(1, 32'h900, 0, 0, 1, 1, 32'hF1);
        expect_ev(EV_GNT_I, 32'h900); expect_ev(EV_SPUR, 32'hF1);
        @(negedge clk);
        chk("t6_after_reset_mem_req", 32'(mem_req_o), 32'h1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hF2);
        expect_ev(EV_RV_I, 32'hF2);
        tick();
        idle_inputs();
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
